// File: rtl/mstage_lsu.sv
// Memory-access stage: one bus request/response per load/store, aligned and extended load data to W.
// Latency: 1 cycle for non-memory ops, at least 3 cycles for memory ops (REQ and RESP wait add to it).
// Backpressure: s_ready only in IDLE; req_* held while req_ready is low; outputs held while m_ready is low.
module mstage_lsu #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] aluX,
    input  logic [31:0] wdataX,
    input  logic        mvalidX,
    input  logic        mwenX,
    input  logic [7:0]  mwmaskX,
    input  logic [2:0]  mrtypeX,
    input  logic [4:0]  rdX,
    input  logic [2:0]  rdregsrcX,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    output logic        req_wen,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb,
    input  logic        resp_valid,
    input  logic [31:0] resp_rdata,
    input  logic        resp_err,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] aluM,
    output logic [31:0] rdataM,
    output logic [4:0]  rdM,
    output logic [2:0]  rdregsrcM,
    output logic        errM
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);

    state_t           state, state_nxt;
    logic [31:0]      wdata_q;
    logic             mwen_q;
    logic [3:0]       mask_q;
    logic [2:0]       mrtype_q;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic             timeout;
    logic [31:0]      shifted, load_ext;

    // Upper mask bits are architecturally unused in a 32-bit datapath.
    logic unused_mask;
    assign unused_mask = &{1'b0, mwmaskX[7:4]};

    assign s_ready   = (state == IDLE);
    assign req_valid = (state == REQ);
    assign m_valid   = (state == DONE);

    assign req_addr  = {aluM[31:2], 2'b00};
    assign req_wen   = mwen_q;
    assign req_wdata = wdata_q << {aluM[1:0], 3'b000};
    assign req_wstrb = mwen_q ? (mask_q << aluM[1:0]) : 4'h0;

    assign cnt_inc = cnt + CNT_W'(1);
    // Counter holds the number of RESP cycles already elapsed; fire on the TIMEOUT-th one.
    assign timeout = (TIMEOUT != 0) && (cnt_inc == TO_V);

    // Misaligned halfword/word accesses simply see zeros shifted in from the top.
    assign shifted = resp_rdata >> {aluM[1:0], 3'b000};

    always_comb begin
        load_ext = shifted;
        case (mrtype_q)
            3'b000:  load_ext = {{24{shifted[7]}},  shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'h0, shifted[7:0]};
            3'b101:  load_ext = {16'h0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (s_valid) state_nxt = mvalidX ? REQ : DONE;
            REQ:  if (req_ready) state_nxt = RESP;
            RESP: if (resp_valid || timeout) state_nxt = DONE;
            DONE: if (m_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wdata_q   <= '0;
            mwen_q    <= 1'b0;
            mask_q    <= '0;
            mrtype_q  <= '0;
            cnt       <= '0;
            aluM      <= '0;
            rdataM    <= '0;
            rdM       <= '0;
            rdregsrcM <= '0;
            errM      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (s_valid) begin
                    aluM      <= aluX;
                    wdata_q   <= wdataX;
                    mwen_q    <= mwenX;
                    mask_q    <= mwmaskX[3:0];
                    mrtype_q  <= mrtypeX;
                    rdM       <= rdX;
                    rdregsrcM <= rdregsrcX;
                    rdataM    <= '0;
                    errM      <= 1'b0;
                end
                REQ: if (req_ready) cnt <= '0;
                RESP: begin
                    cnt <= cnt_inc;
                    // A response arriving on the timeout cycle still wins.
                    if (resp_valid) begin
                        rdataM <= mwen_q ? 32'h0 : load_ext;
                        errM   <= resp_err;
                    end else if (timeout) begin
                        rdataM <= '0;
                        errM   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mstage_lsu.sv
// Directed bench for mstage_lsu built with TIMEOUT=4 so the timeout path is reachable quickly.
module tb_mstage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready;
    logic [31:0] aluX, wdataX;
    logic        mvalidX, mwenX;
    logic [7:0]  mwmaskX;
    logic [2:0]  mrtypeX;
    logic [4:0]  rdX;
    logic [2:0]  rdregsrcX;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        m_valid, m_ready;
    logic [31:0] aluM, rdataM;
    logic [4:0]  rdM;
    logic [2:0]  rdregsrcM;
    logic        errM;

    int checks = 0;
    int errors = 0;
    int ncyc;

    always #5 clk = ~clk;

    mstage_lsu #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .aluX(aluX), .wdataX(wdataX), .mvalidX(mvalidX), .mwenX(mwenX),
        .mwmaskX(mwmaskX), .mrtypeX(mrtypeX), .rdX(rdX), .rdregsrcX(rdregsrcX),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_valid(m_valid), .m_ready(m_ready),
        .aluM(aluM), .rdataM(rdataM), .rdM(rdM), .rdregsrcM(rdregsrcM), .errM(errM)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic mv,
                         input logic wen, input logic [7:0] mask, input logic [2:0] rt,
                         input logic [4:0] rd);
        aluX = a; wdataX = wd; mvalidX = mv; mwenX = wen; mwmaskX = mask;
        mrtypeX = rt; rdX = rd; rdregsrcX = 3'd1;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
    endtask

    // Request accepted on first chance, response on first RESP cycle.
    task automatic xact(input logic [31:0] rdata, input logic err);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        resp_valid = 1'b1; resp_rdata = rdata; resp_err = err;
        step();
        resp_valid = 1'b0; resp_err = 1'b0; resp_rdata = 32'h0;
    endtask

    task automatic retire();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; aluX = '0; wdataX = '0; mvalidX = 1'b0; mwenX = 1'b0;
        mwmaskX = '0; mrtypeX = '0; rdX = '0; rdregsrcX = '0; req_ready = 1'b0;
        resp_valid = 1'b0; resp_rdata = '0; resp_err = 1'b0; m_ready = 1'b0;
        step(); step();
        chk("rst_s_ready", s_ready, 1);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_aluM", aluM, 0);
        chk("rst_errM", errM, 0);
        rst = 1'b0;
        step();

        // Non-memory op, then hold in DONE for 3 cycles with m_ready low.
        issue(32'h1234, 32'h0, 1'b0, 1'b0, 8'h0, 3'b010, 5'd5);
        chk("alu_m_valid", m_valid, 1);
        chk("alu_aluM", aluM, 32'h1234);
        chk("alu_rdataM", rdataM, 0);
        chk("alu_rdM", rdM, 5);
        chk("alu_req_valid", req_valid, 0);
        aluX = 32'hFFFF_FFFF; rdX = 5'd31;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_m_valid", m_valid, 1);
            chk("hold_s_ready", s_ready, 0);
            chk("hold_aluM", aluM, 32'h1234);
            chk("hold_rdM", rdM, 5);
        end
        retire();
        chk("idle_s_ready", s_ready, 1);
        chk("idle_m_valid", m_valid, 0);

        // LB from top byte of word, sign-extended.
        issue(32'h8000_0003, 32'h0, 1'b1, 1'b0, 8'h0, 3'b000, 5'd7);
        chk("lb_req_valid", req_valid, 1);
        chk("lb_req_addr", req_addr, 32'h8000_0000);
        chk("lb_req_wen", req_wen, 0);
        chk("lb_req_wstrb", req_wstrb, 0);
        xact(32'h80FF_0000, 1'b0);
        chk("lb_m_valid", m_valid, 1);
        chk("lb_rdataM", rdataM, 32'hFFFF_FF80);
        chk("lb_errM", errM, 0);
        retire();

        issue(32'h8000_0003, 32'h0, 1'b1, 1'b0, 8'h0, 3'b100, 5'd7);
        xact(32'h80FF_0000, 1'b0);
        chk("lbu_rdataM", rdataM, 32'h0000_0080);
        retire();

        issue(32'h8000_0002, 32'h0, 1'b1, 1'b0, 8'h0, 3'b001, 5'd8);
        xact(32'h80FF_0000, 1'b0);
        chk("lh_rdataM", rdataM, 32'hFFFF_80FF);
        retire();

        issue(32'h8000_0003, 32'h0, 1'b1, 1'b0, 8'h0, 3'b101, 5'd8);
        xact(32'hF0FF_1234, 1'b0);
        chk("lhu_misaligned", rdataM, 32'h0000_00F0);
        retire();

        issue(32'h8000_0001, 32'h0, 1'b1, 1'b0, 8'h0, 3'b010, 5'd9);
        xact(32'hCAFE_BABE, 1'b0);
        chk("lw_misaligned", rdataM, 32'h00CA_FEBA);
        retire();

        // SH with req_ready held low 5 cycles and response on 3rd RESP cycle.
        issue(32'h8000_0002, 32'h0000_ABCD, 1'b1, 1'b1, 8'h03, 3'b001, 5'd0);
        ncyc = 1;
        aluX = 32'h0; wdataX = 32'h0; mwmaskX = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            chk("sh_req_valid", req_valid, 1);
            chk("sh_req_wstrb", req_wstrb, 4'b1100);
            chk("sh_req_wdata", req_wdata, 32'hABCD_0000);
            chk("sh_req_wen", req_wen, 1);
            chk("sh_req_addr", req_addr, 32'h8000_0000);
            step(); ncyc++;
        end
        req_ready = 1'b1;
        step(); ncyc++;
        req_ready = 1'b0;
        step(); ncyc++;
        step(); ncyc++;
        chk("sh_wait_m_valid", m_valid, 0);
        resp_valid = 1'b1; resp_rdata = 32'hDEAD_BEEF;
        step(); ncyc++;
        resp_valid = 1'b0;
        chk("sh_m_valid", m_valid, 1);
        chk("sh_latency", ncyc, 10);
        chk("sh_rdataM", rdataM, 0);
        retire();

        // Timeout: no response within 4 RESP cycles.
        issue(32'h0000_0010, 32'h0, 1'b1, 1'b0, 8'h0, 3'b010, 5'd3);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        step(); step(); step();
        chk("to_pending", m_valid, 0);
        step();
        chk("to_m_valid", m_valid, 1);
        chk("to_errM", errM, 1);
        chk("to_rdataM", rdataM, 0);
        retire();

        // Response on the timeout cycle wins.
        issue(32'h0000_0010, 32'h0, 1'b1, 1'b0, 8'h0, 3'b010, 5'd3);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        step(); step(); step();
        resp_valid = 1'b1; resp_rdata = 32'h0000_0055;
        step();
        resp_valid = 1'b0;
        chk("prio_errM", errM, 0);
        chk("prio_rdataM", rdataM, 32'h55);
        retire();

        issue(32'h0000_0020, 32'h0, 1'b1, 1'b0, 8'h0, 3'b010, 5'd4);
        xact(32'h1122_3344, 1'b1);
        chk("err_errM", errM, 1);
        chk("err_rdataM", rdataM, 32'h1122_3344);
        retire();

        // Reset while waiting in RESP; a later response must be ignored.
        issue(32'h0000_0030, 32'h0, 1'b1, 1'b0, 8'h0, 3'b010, 5'd6);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        rst = 1'b1;
        #2;
        chk("rstmid_s_ready", s_ready, 1);
        chk("rstmid_req_valid", req_valid, 0);
        chk("rstmid_aluM", aluM, 0);
        step();
        rst = 1'b0;
        resp_valid = 1'b1; resp_rdata = 32'h7777_7777;
        step();
        resp_valid = 1'b0;
        chk("late_m_valid", m_valid, 0);
        chk("late_s_ready", s_ready, 1);
        chk("late_rdataM", rdataM, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
